// File: rtl/setpoint_sequencer.sv
// setpoint_sequencer: steps a follower through a programmable table of
// setpoints. Each entry's value is driven as the target, the sequencer waits
// until the follower output matches it exactly, holds for that entry's dwell
// count, then moves on to the next entry.
//
// Build option: define SETPOINT_LOOP_EN to wrap from the last entry back to
// entry 0 forever (no done pulse). Without it, one pass is made and done
// pulses when the last dwell expires.
//
// Control semantics: start is a level, sampled only while idle; abort has
// priority over everything and drops straight to idle holding target and
// index. Table writes are accepted in every state.
// fsm_state is a debug view of the sequencer state (0 idle, 1 settle, 2 dwell).

module setpoint_sequencer #(
    parameter int                  bitwidth       = 8,
    parameter int                  entries        = 4,
    parameter int                  dwell_bitwidth = 8,
    parameter logic [bitwidth-1:0] initial_value  = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        write_enable,
    input  logic [$clog2(entries)-1:0]  write_index,
    input  logic [bitwidth-1:0]         write_value,
    input  logic [dwell_bitwidth-1:0]   write_dwell,
    input  logic                        start,
    input  logic                        abort,
    input  logic [bitwidth-1:0]         follower_value,
    output logic [bitwidth-1:0]         target_value,
    output logic [$clog2(entries)-1:0]  index,
    output logic                        busy,
    output logic                        settled,
    output logic                        done,
    output logic [1:0]                  fsm_state
);

    localparam int iw = $clog2(entries);
    localparam logic [iw-1:0] last_index = iw'(entries - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [bitwidth-1:0]       value_table [entries];
    logic [dwell_bitwidth-1:0] dwell_table [entries];

    logic [dwell_bitwidth-1:0] count_q, count_n;
    logic [bitwidth-1:0]       target_n;
    logic [iw-1:0]             index_n;
    logic                      done_n;
    logic                      write_ok;

    // Exact equality on the full width; there is no tolerance band.
    assign settled   = (follower_value == target_value);
    assign fsm_state = state_q;
    assign write_ok  = write_enable && (int'(write_index) < entries);

    // Setpoint table: cleared on reset, written by the host at any time.
    // A load in the same cycle as a write of that entry sees the old contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < entries; i++) begin
                value_table[i] <= initial_value;
                dwell_table[i] <= '0;
            end
        end else if (write_ok) begin
            value_table[write_index] <= write_value;
            dwell_table[write_index] <= write_dwell;
        end
    end

    // State register plus the registered datapath and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            target_value <= initial_value;
            index        <= '0;
            count_q      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_n;
            target_value <= target_n;
            index        <= index_n;
            count_q      <= count_n;
            busy         <= (state_n != IDLE);
            done         <= done_n;
        end
    end

    // Next-state and datapath decisions; everything holds unless a branch acts.
    always_comb begin
        state_n  = state_q;
        target_n = target_value;
        index_n  = index;
        count_n  = count_q;
        done_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    index_n  = '0;
                    target_n = value_table[0];
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (settled) begin
                    count_n = dwell_table[index];
                    state_n = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (count_q != '0) begin
                    count_n = count_q - 1'b1;
                end else if (index != last_index) begin
                    index_n  = index + iw'(1);
                    target_n = value_table[index + iw'(1)];
                    state_n  = SETTLE;
                end else begin
`ifdef SETPOINT_LOOP_EN
                    index_n  = '0;
                    target_n = value_table[0];
                    state_n  = SETTLE;
`else
                    done_n   = 1'b1;
                    state_n  = IDLE;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_setpoint_sequencer.sv
// tb_setpoint_sequencer: directed bench for setpoint_sequencer using the table
// {5,12,2,7} with dwell {3,0,1,2} and a follower model that steps one count
// per clock toward the target. Expected per-cycle outputs are hand-derived
// timelines relative to the edge that samples start.

module tb_setpoint_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_enable = 1'b0;
    logic [1:0] write_index = 2'd0;
    logic [7:0] write_value = 8'd0;
    logic [7:0] write_dwell = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] follower_value = 8'd0;
    logic [7:0] target_value;
    logic [1:0] index;
    logic       busy;
    logic       settled;
    logic       done;
    logic [1:0] fsm_state;

    logic       follow_en = 1'b0;
    logic       follower_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    int tbl_val [4] = '{5, 12, 2, 7};
    int tbl_dw  [4] = '{3, 0, 1, 2};

    setpoint_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .write_enable   (write_enable),
        .write_index    (write_index),
        .write_value    (write_value),
        .write_dwell    (write_dwell),
        .start          (start),
        .abort          (abort),
        .follower_value (follower_value),
        .target_value   (target_value),
        .index          (index),
        .busy           (busy),
        .settled        (settled),
        .done           (done),
        .fsm_state      (fsm_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Follower model: one count per clock toward the current target.
    always @(posedge clock) begin
        if (follower_clear)
            follower_value <= 8'd0;
        else if (follow_en) begin
            if (follower_value < target_value)
                follower_value <= follower_value + 8'd1;
            else if (follower_value > target_value)
                follower_value <= follower_value - 8'd1;
        end
    end

    // Expected active index k edges after the start edge (single pass).
    function automatic int exp_idx(input int k);
        if (k < 10) return 0;
        if (k < 19) return 1;
        if (k < 32) return 2;
        return 3;
    endfunction

    function automatic int exp_settled(input int k);
        return ((k >= 5 && k <= 9) || (k >= 17 && k <= 18) ||
                (k >= 29 && k <= 31) || (k >= 37)) ? 1 : 0;
    endfunction

    task automatic write_entry(input int idx, input int val, input int dw);
        write_enable = 1'b1;
        write_index  = 2'(idx);
        write_value  = 8'(val);
        write_dwell  = 8'(dw);
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic prep_follower();
        follow_en      = 1'b0;
        follower_clear = 1'b1;
        @(negedge clock);
        follower_clear = 1'b0;
    endtask

    // One sequence run with optional mid-run start pulse, abort and write.
    task automatic run_pass(input int restart_at, input int abort_at,
                            input int write_at, input string name);
        int last;
        int ei, et, eb, ed, es;
`ifdef SETPOINT_LOOP_EN
        last = 47;
`else
        last = 45;
`endif
        prep_follower();
        start = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            if (abort_at >= 0 && k > abort_at) begin
                ei = exp_idx(abort_at); et = tbl_val[ei]; eb = 0; ed = 0;
                es = exp_settled(abort_at);
            end else if (k >= 41) begin
`ifdef SETPOINT_LOOP_EN
                ei = 0; et = (write_at >= 0) ? 9 : 5; eb = 1; ed = 0;
                es = (k >= 43) ? 1 : 0;
`else
                ei = 3; et = 7; eb = 0; ed = (k == 41) ? 1 : 0; es = 1;
`endif
            end else begin
                ei = exp_idx(k); et = tbl_val[ei]; eb = 1; ed = 0;
                es = exp_settled(k);
            end
            checks++;
            if (target_value !== 8'(et)) begin
                failures++;
                $display("FAIL %s target k=%0d got=%0d exp=%0d", name, k, target_value, et);
            end
            checks++;
            if (index !== 2'(ei)) begin
                failures++;
                $display("FAIL %s index k=%0d got=%0d exp=%0d", name, k, index, ei);
            end
            checks++;
            if (busy !== 1'(eb)) begin
                failures++;
                $display("FAIL %s busy k=%0d got=%0b exp=%0d", name, k, busy, eb);
            end
            checks++;
            if (done !== 1'(ed)) begin
                failures++;
                $display("FAIL %s done k=%0d got=%0b exp=%0d", name, k, done, ed);
            end
            checks++;
            if (settled !== 1'(es)) begin
                failures++;
                $display("FAIL %s settled k=%0d got=%0b exp=%0d", name, k, settled, es);
            end
            if (k == 0) follow_en = 1'b1;
            start = (k == restart_at);
            abort = (k == abort_at);
            if (k == write_at) begin
                write_enable = 1'b1; write_index = 2'd0;
                write_value = 8'd9; write_dwell = 8'd3;
            end else begin
                write_enable = 1'b0;
            end
        end
        start = 1'b0;
        write_enable = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (target_value !== 8'd0 || index !== 2'd0 || busy !== 1'b0 ||
            done !== 1'b0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got tgt=%0d idx=%0d busy=%0b done=%0b st=%0d exp 0/0/0/0/0",
                     target_value, index, busy, done, fsm_state);
        end
        checks++;
        if (settled !== 1'b1) begin
            failures++;
            $display("FAIL reset_settled got=%0b exp=1", settled);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) write_entry(i, tbl_val[i], tbl_dw[i]);
    endtask

    task automatic test_full_pass();
        run_pass(-1, -1, -1, "full_pass");
    endtask

    task automatic test_start_while_busy();
        run_pass(15, -1, -1, "start_busy");
    endtask

    task automatic test_write_active();
        run_pass(-1, -1, 3, "write_active");
        write_entry(0, 5, 3);
    endtask

    task automatic test_abort();
        run_pass(-1, 30, -1, "abort_dwell");
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || target_value !== 8'd2 || index !== 2'd2) begin
            failures++;
            $display("FAIL abort_start_idle got busy=%0b tgt=%0d idx=%0d exp 0/2/2",
                     busy, target_value, index);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int ei, eb, ed;
        prep_follower();
        start = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clock);
            if (k == 2) begin
                checks++;
                if (busy !== 1'b1 || target_value !== 8'd5 || fsm_state !== 2'd1) begin
                    failures++;
                    $display("FAIL pre_reset got busy=%0b tgt=%0d st=%0d exp 1/5/1",
                             busy, target_value, fsm_state);
                end
            end
            if (k == 3) begin
                checks++;
                if (target_value !== 8'd0 || busy !== 1'b0 || index !== 2'd0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid got tgt=%0d busy=%0b idx=%0d done=%0b exp 0/0/0/0",
                             target_value, busy, index, done);
                end
            end
            if (k == 0) begin start = 1'b0; follow_en = 1'b1; end
            reset = (k == 2);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_done got done=%0b busy=%0b exp 0/0", done, busy);
            end
        end
        // Table was cleared: every entry is value 0, dwell 0.
        prep_follower();
        start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            ei = (k < 2) ? 0 : (k < 4) ? 1 : (k < 6) ? 2 : 3;
            eb = (k < 8) ? 1 : 0;
            ed = (k == 8) ? 1 : 0;
`ifdef SETPOINT_LOOP_EN
            if (k == 8) begin ei = 0; eb = 1; ed = 0; end
`endif
            checks++;
            if (target_value !== 8'd0 || index !== 2'(ei) || busy !== 1'(eb) || done !== 1'(ed)) begin
                failures++;
                $display("FAIL cleared_run k=%0d got tgt=%0d idx=%0d busy=%0b done=%0b exp 0/%0d/%0d/%0d",
                         k, target_value, index, busy, done, ei, eb, ed);
            end
            if (k == 0) start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_start_while_busy();
        test_write_active();
        test_abort();
        test_reset_mid_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
